// File: rtl/charge_detect_if.sv
// Tone input and decoded-note outputs of the charge_detect receiver.
// The master drives the tone; the slave is the decoder.
`timescale 1ns/1ps
interface charge_detect_if;
    logic       tone;
    logic [2:0] cur_note;
    logic       note_vld;
    logic [2:0] note_id;
    logic [2:0] note_dur;
    logic [2:0] seq_idx;
    logic       charge_det;

    modport master (
        output tone,
        input  cur_note, note_vld, note_id, note_dur, seq_idx, charge_det
    );

    modport slave (
        input  tone,
        output cur_note, note_vld, note_id, note_dur, seq_idx, charge_det
    );
endinterface

// File: rtl/charge_detect.sv
// Piezo tone receiver: classifies square-wave periods into notes, emits note events
// and detects the six-note charge fanfare. Define CHARGE_DETECT_DUR_CHECK_EN to also match durations.
`timescale 1ns/1ps
module charge_detect #(
    parameter int unsigned FAST_SIM = 1,
    parameter int unsigned TOL      = 256
) (
    input  logic           clk,
    input  logic           rst,
    charge_detect_if.slave bus
);
    localparam int unsigned UNIT_LG = (FAST_SIM != 0) ? 18 : 22;
    localparam logic [14:0] CNT_MAX = '1;
    localparam logic [14:0] PER_G6  = 15'd31888;
    localparam logic [14:0] PER_C7  = 15'd23890;
    localparam logic [14:0] PER_E7  = 15'd18960;
    localparam logic [14:0] PER_G7  = 15'd15944;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_G6   = 3'd1,
        NOTE_C7   = 3'd2,
        NOTE_E7   = 3'd3,
        NOTE_G7   = 3'd4
    } note_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_M5   = 3'd5
    } seq_e;

    function automatic logic near(input logic [14:0] p, input logic [14:0] nom);
        logic [14:0] diff;
        diff = (p >= nom) ? (p - nom) : (nom - p);
        return 32'(diff) <= TOL;
    endfunction

    function automatic note_e classify(input logic [14:0] p);
        if (p == CNT_MAX)         return NOTE_NONE;
        else if (near(p, PER_G6)) return NOTE_G6;
        else if (near(p, PER_C7)) return NOTE_C7;
        else if (near(p, PER_E7)) return NOTE_E7;
        else if (near(p, PER_G7)) return NOTE_G7;
        else                      return NOTE_NONE;
    endfunction

    function automatic note_e seq_note(input seq_e s);
        case (s)
            S_IDLE:  return NOTE_G6;
            S_M1:    return NOTE_C7;
            S_M2:    return NOTE_E7;
            S_M3:    return NOTE_G7;
            S_M4:    return NOTE_E7;
            S_M5:    return NOTE_G7;
            default: return NOTE_NONE;
        endcase
    endfunction

`ifdef CHARGE_DETECT_DUR_CHECK_EN
    function automatic logic [2:0] seq_dur(input seq_e s);
        case (s)
            S_IDLE:  return 3'd2;
            S_M1:    return 3'd2;
            S_M2:    return 3'd2;
            S_M3:    return 3'd3;
            S_M4:    return 3'd1;
            S_M5:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction
`endif

    logic        sync1_q, sync2_q, sync3_q;
    logic        rise, sat, note_chg;
    logic [14:0] per_q, per_d;
    note_e       cls, cand_q, cand_d, cur_q, cur_d, prev_q;
    logic [1:0]  match_q, match_d;
    logic [24:0] dur_q, dur_d;
    logic [25:0] dur_rnd, dur_units;
    logic        vld_q, vld_d;
    note_e       id_q, id_d;
    logic [2:0]  ndur_q, ndur_d;
    seq_e        state_q, state_d;
    logic        charge_q, charge_d;
    logic        ev_hit, ev_first;

    assign rise = sync2_q & ~sync3_q;
    assign sat  = (per_q == CNT_MAX);
    assign cls  = classify(per_q);

    always_comb begin
        per_d = per_q;
        if (rise)      per_d = 15'd1;
        else if (!sat) per_d = per_q + 15'd1;
    end

    // A rising edge takes priority over silence; the saturated period then classifies as NONE.
    always_comb begin
        cand_d  = cand_q;
        match_d = match_q;
        cur_d   = cur_q;
        if (match_q == 2'd3 && cand_q != cur_q) cur_d = cand_q;
        if (rise) begin
            if (cls == cand_q) begin
                if (match_q != 2'd3) match_d = match_q + 2'd1;
            end else begin
                cand_d  = cls;
                match_d = 2'd0;
            end
        end else if (sat) begin
            cand_d  = NOTE_NONE;
            match_d = 2'd0;
            cur_d   = NOTE_NONE;
        end
    end

    // prev_q lags cur_q by one clock, so the event and the duration clear land together.
    assign note_chg  = (prev_q != cur_q);
    assign dur_rnd   = {1'b0, dur_q} + (26'd1 << (UNIT_LG - 1));
    assign dur_units = dur_rnd >> UNIT_LG;

    always_comb begin
        dur_d = dur_q;
        if (note_chg)                                 dur_d = '0;
        else if (cur_q != NOTE_NONE && dur_q != '1)   dur_d = dur_q + 25'd1;
        vld_d  = note_chg && (prev_q != NOTE_NONE);
        id_d   = vld_d ? prev_q : id_q;
        ndur_d = ndur_q;
        if (vld_d) ndur_d = (dur_units > 26'd7) ? 3'd7 : dur_units[2:0];
    end

`ifdef CHARGE_DETECT_DUR_CHECK_EN
    assign ev_hit   = (id_q == seq_note(state_q)) && (ndur_q == seq_dur(state_q));
    assign ev_first = (id_q == NOTE_G6) && (ndur_q == seq_dur(S_IDLE));
`else
    assign ev_hit   = (id_q == seq_note(state_q));
    assign ev_first = (id_q == NOTE_G6);
`endif

    always_comb begin
        state_d  = state_q;
        charge_d = 1'b0;
        if (vld_q) begin
            if (ev_hit) begin
                case (state_q)
                    S_IDLE:  state_d = S_M1;
                    S_M1:    state_d = S_M2;
                    S_M2:    state_d = S_M3;
                    S_M3:    state_d = S_M4;
                    S_M4:    state_d = S_M5;
                    S_M5: begin
                        state_d  = S_IDLE;
                        charge_d = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end else if (ev_first) begin
                state_d = S_M1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            per_q    <= '0;
            cand_q   <= NOTE_NONE;
            match_q  <= '0;
            cur_q    <= NOTE_NONE;
            prev_q   <= NOTE_NONE;
            dur_q    <= '0;
            vld_q    <= 1'b0;
            id_q     <= NOTE_NONE;
            ndur_q   <= '0;
            state_q  <= S_IDLE;
            charge_q <= 1'b0;
        end else begin
            sync1_q  <= bus.tone;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            per_q    <= per_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            cur_q    <= cur_d;
            prev_q   <= cur_q;
            dur_q    <= dur_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
            ndur_q   <= ndur_d;
            state_q  <= state_d;
            charge_q <= charge_d;
        end
    end

    assign bus.cur_note   = cur_q;
    assign bus.note_vld   = vld_q;
    assign bus.note_id    = id_q;
    assign bus.note_dur   = ndur_q;
    assign bus.seq_idx    = state_q;
    assign bus.charge_det = charge_q;
endmodule

// File: doc/charge_detect.md
# charge_detect

Tone receiver and decoder for the piezo fanfare output. It samples a single square-wave tone input and classifies its period into one of four notes (G6/C7/E7/G7). It emits one event per completed note, carrying the note's identity and rounded duration. It also asserts a one-cycle pulse when the full six-note charge sequence is recognised. It sits in the self-test / verification path, listening to the same `piezo` net the tone generator drives.

## Interface
- `FAST_SIM`, 1: duration unit is 2^18 clocks when 1 and 2^22 clocks when 0, matching the generator's 16x duration speed-up.
- `TOL`, 256: allowed period error in clocks for note classification, inclusive.
- `clk` input 1: 50 MHz system clock.
- `rst` input 1: synchronous, active-high reset.
- `tone` input 1: asynchronous square-wave input, normally the piezo net.
- `cur_note` output 3: currently locked note. 0=NONE, 1=G6, 2=C7, 3=E7, 4=G7.
- `note_vld` output 1: one-cycle pulse when a locked non-NONE note ends.
- `note_id` output 3: note code of the ended note; valid with `note_vld`.
- `note_dur` output 3: rounded duration of the ended note in units; valid with `note_vld`.
- `seq_idx` output 3: number of sequence notes matched so far, 0..5.
- `charge_det` output 1: one-cycle pulse when the sixth note of the sequence matches.

## Operation
- Input path: `tone` passes through a 2-flop synchronizer. A rising edge is detected from the synchronized value and its registered copy.
- Period counter: 15 bits, increments every clock and saturates at 0x7FFF.
  - On a rising edge, the current count is classified and the counter is reloaded to 1.
- Classification is against nominal periods G6=31888, C7=23890, E7=18960, G7=15944.
  - A match requires |period - nominal| <= TOL. Any other period classifies as NONE.
  - A saturated period also classifies as NONE.
- Lock logic: registers `cand` (3 bits) and `match_cnt` (2 bits, saturating at 3).
  - Each classified edge with class == `cand` increments `match_cnt`.
  - A classified edge with a different class sets `cand` to that class and clears `match_cnt`.
  - When `match_cnt` reaches 3 (four consecutive equal periods) and `cand` != `cur_note`, `cur_note` takes `cand`.
- Silence: when the period counter saturates, `cur_note` becomes NONE immediately, `cand` becomes NONE and `match_cnt` clears. No edge is needed.
- Duration counter: 25 bits, saturating.
  - Increments every clock while `cur_note` != NONE.
  - Clears whenever `cur_note` changes.
- Note event: when `cur_note` changes from a non-NONE value L, the block pulses `note_vld` with `note_id`=L.
  - `note_dur` = (dur + half unit) >> log2(unit), saturated at 7.
  - When FAST_SIM=0, unit = 2^22 clocks; when FAST_SIM=1, unit = 2^18 clocks.
- Sequence FSM: states IDLE, M1, M2, M3, M4, M5. `seq_idx` is the state's index.
  - The expected sequence is G6, C7, E7, G7, E7, G7.
  - The FSM advances only on `note_vld`.
  - Match in state Mk: move to M(k+1). A match in M5 pulses `charge_det` and returns to IDLE.
  - Mismatch: if the event itself matches entry 0 (G6), go to M1; otherwise go to IDLE.
  - Silence between notes does not reset the FSM.

## Timing
- After `rst`, every output is 0 and the FSM is IDLE. All counters, `cand` and the synchronizer clear.
- Edge latency: `tone` rising edge to classification is 3 clocks.
- `cur_note` updates in the clock after the fourth consecutive matching edge is classified.
- `note_vld` is asserted in the clock after `cur_note` changes. It is exactly one cycle wide.
- `charge_det` is asserted in the clock after the sixth matching `note_vld`. It is exactly one cycle wide.
- Simultaneous saturation and rising edge: the edge wins. The counter reloads to 1 and the period classifies as NONE.
- A note change directly from L to M (no silence) emits one event for L. The duration counter clears in the same clock.
- `rst` mid-note: no event is emitted and the FSM returns to IDLE.

## Configuration
- `CHARGE_DETECT_DUR_CHECK_EN` defined: a sequence match also requires `note_dur` to equal the expected unit count for that position: 2, 2, 2, 3, 1, 4.
- Not defined: only `note_id` order is checked, and `note_dur` is reported but ignored by the FSM.

## Test plan
- 20 periods of a 23890-clock square wave, then a held-low input: `cur_note`=2 after the fourth edge; `note_vld` with `note_id`=2 about 32767 clocks after the last edge; `cur_note`=0.
- Period 24200 (outside TOL=256): `cur_note` stays 0 and no `note_vld` occurs.
- Full generator fanfare, FAST_SIM=1, durations 2^19, 2^19, 2^19, 3·2^18, 2^18, 2^20: six events with `note_dur` 2, 2, 2, 3, 1, 4; one `charge_det` pulse; `seq_idx` ends at 0.
- Sequence G6, C7, G6, C7, E7, G7, E7, G7: FSM restarts to M1 on the third note; exactly one `charge_det`.
- With `CHARGE_DETECT_DUR_CHECK_EN` defined, fourth note lasting 2^19 (dur 2): no `charge_det`. Without the macro: `charge_det` pulses.
- `rst` asserted during the fifth note: all outputs 0 next clock; the following note produces no `note_vld` for the interrupted one.
